// File: rtl/clock_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : clock_seq_pkg
// Purpose  : Shared definitions for the clock-group reset sequencer: the FSM
//            state encoding, the domain-index width and the delay-counter
//            width helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package clock_seq_pkg;

  // Width of the re-reset request domain index.
  localparam int DOM_IDX_W = 3;

  // Sequencer states, explicitly encoded in three bits.
  typedef enum logic [2:0] {
    ST_HOLD    = 3'd0,
    ST_CLK_ON  = 3'd1,
    ST_RST_OFF = 3'd2,
    ST_RUN     = 3'd3,
    ST_RERESET = 3'd4
  } seq_state_e;

  // The delay counter must hold the larger of the two wait lengths.
  function automatic int cnt_width(input int hold_cycles, input int stagger_cycles);
    int max_wait;
    max_wait = (hold_cycles > stagger_cycles) ? hold_cycles : stagger_cycles;
    return $clog2(max_wait + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_delay_counter.sv
`default_nettype none
// ============================================================================
// Module   : seq_delay_counter
// Purpose  : Per-state delay timer. Restarted from zero by clear_i (driven on
//            every FSM state change); expire_o asserts once the number of
//            cycles remaining before limit_i is reached drops to zero. The
//            count stops at the limit and never wraps.
// Ports    : clock    - block clock
//            reset    - synchronous active-high reset
//            clear_i  - restart the delay
//            limit_i  - terminal count for the current state
//            expire_o - delay elapsed (combinational from the count register)
// Revision : 1.0 - initial release
// ============================================================================
module seq_delay_counter #(
  parameter int CNT_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear_i,
  input  logic [CNT_W-1:0] limit_i,
  output logic             expire_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (count_q != limit_i) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire_o = (count_q == limit_i);

endmodule
`default_nettype wire

// File: rtl/clock_group_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : clock_group_reset_sequencer
// Purpose  : After global reset, enables each domain clock and then releases
//            that domain's reset, one domain at a time with a programmable
//            stagger. Once every domain runs, services single-domain
//            re-reset requests over a valid/ready handshake.
// Ports    : clock, reset   - block clock, synchronous active-high reset
//            out_clock_en   - per-domain clock-gate enable
//            out_reset      - per-domain reset, active-high
//            seq_done       - all domains released
//            req_valid/req_domain/req_ready - re-reset request handshake
//            resp_valid/resp_err            - one-cycle completion pulse
// Revision : 1.0 - initial release
// ============================================================================
module clock_group_reset_sequencer
  import clock_seq_pkg::*;
#(
  parameter int N_DOMAINS      = 2,
  parameter int HOLD_CYCLES    = 16,
  parameter int STAGGER_CYCLES = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  output logic [N_DOMAINS-1:0] out_clock_en,
  output logic [N_DOMAINS-1:0] out_reset,
  output logic                 seq_done,
  input  logic                 req_valid,
  input  logic [DOM_IDX_W-1:0] req_domain,
  output logic                 req_ready,
  output logic                 resp_valid,
  output logic                 resp_err
);

  localparam int CNT_W = cnt_width(HOLD_CYCLES, STAGGER_CYCLES);

  // The first post-reset edge already counts as a HOLD cycle, so HOLD
  // compares against the full length; every other state is entered on an
  // edge and its first counted cycle is the following one.
  localparam logic [CNT_W-1:0] c_hold_lim    = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] c_rereset_lim = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_stagger_lim = CNT_W'(STAGGER_CYCLES - 1);
  localparam logic [DOM_IDX_W-1:0] c_last_dom = DOM_IDX_W'(N_DOMAINS - 1);
  localparam logic [DOM_IDX_W:0]   c_n_dom    = (DOM_IDX_W + 1)'(N_DOMAINS);

  seq_state_e                 state_q, state_d;
  logic [DOM_IDX_W-1:0]       dom_q, dom_d;
  logic [N_DOMAINS-1:0]       clk_en_q, clk_en_d;
  logic [N_DOMAINS-1:0]       rst_q, rst_d;
  logic                       done_q, done_d;
  logic                       ready_q, ready_d;
  logic                       rvalid_q, rvalid_d;
  logic                       rerr_q, rerr_d;

  logic [CNT_W-1:0]           lim;
  logic                       expire;
  logic                       cnt_clear;
  logic                       fire;
  logic                       req_in_range;
  logic [N_DOMAINS-1:0]       dom_mask;
  logic [N_DOMAINS-1:0]       req_mask;

  assign fire         = req_valid & ready_q;
  assign req_in_range = ({1'b0, req_domain} < c_n_dom);
  assign dom_mask     = N_DOMAINS'(1) << dom_q;
  assign req_mask     = N_DOMAINS'(1) << req_domain;

  always_comb begin
    state_d  = state_q;
    dom_d    = dom_q;
    clk_en_d = clk_en_q;
    rst_d    = rst_q;
    done_d   = done_q;
    rvalid_d = 1'b0;
    rerr_d   = 1'b0;
    lim      = c_stagger_lim;

    case (state_q)
      ST_HOLD: begin
        lim = c_hold_lim;
        if (expire) begin
          clk_en_d = clk_en_q | N_DOMAINS'(1);
          state_d  = ST_CLK_ON;
        end
      end
      ST_CLK_ON: begin
        if (expire) begin
          rst_d   = rst_q & ~dom_mask;
          state_d = ST_RST_OFF;
        end
      end
      ST_RST_OFF: begin
        if (expire) begin
          if (dom_q < c_last_dom) begin
            clk_en_d = clk_en_q | (dom_mask << 1);
            dom_d    = dom_q + DOM_IDX_W'(1);
            state_d  = ST_CLK_ON;
          end else begin
            done_d  = 1'b1;
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (fire) begin
          if (req_in_range) begin
            rst_d   = rst_q | req_mask;
            dom_d   = req_domain;
            state_d = ST_RERESET;
          end else begin
            // Out-of-range domain: answer with an error, touch nothing.
            rvalid_d = 1'b1;
            rerr_d   = 1'b1;
          end
        end
      end
      ST_RERESET: begin
        lim = c_rereset_lim;
        // The domain clock stays enabled: its reset is synchronous.
        if (expire) begin
          rst_d    = rst_q & ~dom_mask;
          rvalid_d = 1'b1;
          state_d  = ST_RUN;
        end
      end
      default: begin
        state_d = ST_HOLD;
      end
    endcase

    // Registered ready tracks the state being entered.
    ready_d = (state_d == ST_RUN);
  end

  // Restart the delay on every state change; keep it parked while in RUN.
  assign cnt_clear = (state_d != state_q) || (state_q == ST_RUN);

  seq_delay_counter #(
    .CNT_W (CNT_W)
  ) u_delay (
    .clock    (clock),
    .reset    (reset),
    .clear_i  (cnt_clear),
    .limit_i  (lim),
    .expire_o (expire)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_HOLD;
      dom_q    <= '0;
      clk_en_q <= '0;
      rst_q    <= '1;
      done_q   <= 1'b0;
      ready_q  <= 1'b0;
      rvalid_q <= 1'b0;
      rerr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      dom_q    <= dom_d;
      clk_en_q <= clk_en_d;
      rst_q    <= rst_d;
      done_q   <= done_d;
      ready_q  <= ready_d;
      rvalid_q <= rvalid_d;
      rerr_q   <= rerr_d;
    end
  end

  assign out_clock_en = clk_en_q;
  assign out_reset    = rst_q;
  assign seq_done     = done_q;
  assign req_ready    = ready_q;
  assign resp_valid   = rvalid_q;
  assign resp_err     = rerr_q;

endmodule
`default_nettype wire

// File: tb/tb_clock_group_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_clock_group_reset_sequencer
// Purpose  : Self-checking bench for clock_group_reset_sequencer: a directed
//            vector table, hand-written abort sequences, random requests
//            against a timestamp-based reference model, and a minimal
//            single-domain configuration.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clock_group_reset_sequencer;

  localparam int N  = 2;
  localparam int H  = 16;
  localparam int S  = 4;
  localparam int TD = H + 2 * N * S;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // Default-parameter instance
  logic       rst_a;
  logic       req_v;
  logic [2:0] req_d;
  logic [1:0] en, ro;
  logic       done, rdy, rv, re;

  // Minimal single-domain instance
  logic       rst_b;
  logic       v_b;
  logic [2:0] d_b;
  logic [0:0] en_b, ro_b;
  logic       done_b, rdy_b, rv_b, re_b;

  clock_group_reset_sequencer dut (
    .clock(clk), .reset(rst_a), .out_clock_en(en), .out_reset(ro),
    .seq_done(done), .req_valid(req_v), .req_domain(req_d),
    .req_ready(rdy), .resp_valid(rv), .resp_err(re)
  );

  clock_group_reset_sequencer #(
    .N_DOMAINS(1), .HOLD_CYCLES(1), .STAGGER_CYCLES(1)
  ) dut1 (
    .clock(clk), .reset(rst_b), .out_clock_en(en_b), .out_reset(ro_b),
    .seq_done(done_b), .req_valid(v_b), .req_domain(d_b),
    .req_ready(rdy_b), .resp_valid(rv_b), .resp_err(re_b)
  );

  int total = 0;
  int bad   = 0;

  // Reference-model timeline (cycle numbers since reset release)
  int cyc;
  int rr_dom, rr_start, rr_end, err_at;

  typedef struct {
    int         cyc;
    logic       v;
    logic [2:0] d;
    logic [7:0] exp;  // {en[1:0], rst[1:0], done, ready, resp_valid, resp_err}
  } vec_t;

  vec_t tbl[16];

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [7:0] dut_vec();
    return {en, ro, done, rdy, rv, re};
  endfunction

  // Expected outputs at cycle c, from the documented timing rules.
  function automatic logic [7:0] model(input int c);
    logic [1:0] e, r;
    logic       dn, rd, v, er, in_rr;
    for (int i = 0; i < N; i++) begin
      e[i] = (c >= H + 2 * i * S);
      r[i] = (c <  H + (2 * i + 1) * S);
    end
    dn    = (c >= TD);
    in_rr = (c >= rr_start) && (c < rr_end);
    if (in_rr) r = r | (2'b01 << rr_dom);
    rd = dn && !in_rr;
    v  = (c == rr_end) || (c == err_at);
    er = (c == err_at);
    return {e, r, dn, rd, v, er};
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%b want=%b (en,rst,done,ready,rv,err)",
               name, cyc, act, exp);
    end
  endtask

  // Drive request inputs for the current cycle and record any fire.
  task automatic drive_req(input logic v, input int d);
    logic [7:0] e;
    req_v = v;
    req_d = 3'(d);
    e = model(cyc);
    if (v && e[2]) begin
      if (d < N) begin
        rr_dom   = d;
        rr_start = cyc + 1;
        rr_end   = cyc + 1 + H;
      end else begin
        err_at = cyc + 1;
      end
    end
  endtask

  task automatic do_reset(input int n);
    rst_a = 1'b1;
    req_v = 1'b0;
    req_d = 3'd0;
    repeat (n) step();
    check("reset_state", dut_vec(), 8'b0011_0000);
    rst_a    = 1'b0;
    cyc      = 0;
    rr_dom   = 0;
    rr_start = -100;
    rr_end   = -100;
    err_at   = -100;
  endtask

  // mode 0: idle, 1: random valid/domain, 2: valid held high
  task automatic run_model(input int ncyc, input int mode);
    for (int k = 0; k < ncyc; k++) begin
      step();
      check("model", dut_vec(), model(cyc));
      case (mode)
        1:       drive_req(1'($urandom_range(0, 1)), $urandom_range(0, 7));
        2:       drive_req(1'b1, $urandom_range(0, 7));
        default: drive_req(1'b0, 0);
      endcase
      cyc++;
    end
  endtask

  initial begin
    rst_a = 1'b1; req_v = 1'b0; req_d = 3'd0;
    rst_b = 1'b1; v_b = 1'b0; d_b = 3'd0;

    tbl[0]  = '{0,  1'b0, 3'd0, 8'b00_11_0000};
    tbl[1]  = '{15, 1'b0, 3'd0, 8'b00_11_0000};
    tbl[2]  = '{16, 1'b0, 3'd0, 8'b01_11_0000};
    tbl[3]  = '{19, 1'b0, 3'd0, 8'b01_11_0000};
    tbl[4]  = '{20, 1'b0, 3'd0, 8'b01_10_0000};
    tbl[5]  = '{23, 1'b0, 3'd0, 8'b01_10_0000};
    tbl[6]  = '{24, 1'b0, 3'd0, 8'b11_10_0000};
    tbl[7]  = '{27, 1'b0, 3'd0, 8'b11_10_0000};
    tbl[8]  = '{28, 1'b0, 3'd0, 8'b11_00_0000};
    tbl[9]  = '{31, 1'b0, 3'd0, 8'b11_00_0000};
    tbl[10] = '{32, 1'b1, 3'd1, 8'b11_00_1100};  // request domain 1 fires
    tbl[11] = '{33, 1'b0, 3'd0, 8'b11_10_1000};
    tbl[12] = '{48, 1'b0, 3'd0, 8'b11_10_1000};
    tbl[13] = '{49, 1'b1, 3'd5, 8'b11_00_1110};  // done pulse; invalid request
    tbl[14] = '{50, 1'b0, 3'd0, 8'b11_00_1111};
    tbl[15] = '{51, 1'b0, 3'd0, 8'b11_00_1100};

    // Directed table against default parameters
    do_reset(5);
    begin
      int c;
      c = -1;
      for (int i = 0; i < 16; i++) begin
        while (c < tbl[i].cyc) begin
          step();
          c++;
        end
        cyc = c;
        check("table", dut_vec(), tbl[i].exp);
        req_v = tbl[i].v;
        req_d = tbl[i].d;
      end
    end

    // Reset asserted mid-sequence at cycle 22, then an identical replay
    do_reset(2);
    run_model(23, 0);
    rst_a = 1'b1;
    step();
    check("abort_seq", dut_vec(), 8'b0011_0000);
    do_reset(3);
    run_model(40, 0);

    // Reset asserted five cycles into a re-reset
    do_reset(2);
    run_model(32, 0);
    step();
    check("model", dut_vec(), model(cyc));
    drive_req(1'b1, 0);
    cyc++;
    run_model(5, 0);
    rst_a = 1'b1;
    step();
    check("abort_rereset", dut_vec(), 8'b0011_0000);
    do_reset(2);
    run_model(60, 1);

    // req_valid held high from cycle 0
    do_reset(2);
    run_model(100, 2);

    // Random request traffic
    do_reset(3);
    run_model(300, 1);

    // Single domain, one-cycle hold and stagger
    rst_b = 1'b1;
    step();
    total++;
    if ({en_b, ro_b, done_b, rdy_b, rv_b, re_b} !== 6'b01_0000) begin
      bad++;
      $display("FAIL n1_reset got=%b want=%b", {en_b, ro_b, done_b, rdy_b, rv_b, re_b}, 6'b01_0000);
    end
    rst_b = 1'b0;
    for (int c = 0; c < 6; c++) begin
      logic [5:0] exp1;
      step();
      exp1 = {1'(c >= 1), 1'(c < 2), 1'(c >= 3), 1'(c >= 3), 2'b00};
      total++;
      if ({en_b, ro_b, done_b, rdy_b, rv_b, re_b} !== exp1) begin
        bad++;
        $display("FAIL n1_seq cyc=%0d got=%b want=%b", c,
                 {en_b, ro_b, done_b, rdy_b, rv_b, re_b}, exp1);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
